// File: rtl/dm_lsu_pkg.sv
// +----------------------------------------------------------------------+
// | dm_lsu_pkg : shared encodings and defaults for the load/store unit   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package dm_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [23:0] DM_BASE_HI = 24'h710000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dm_lsu_lane.sv
// +----------------------------------------------------------------------+
// | dm_lsu_lane : byte-lane load extract/extend and store merge          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte  = rd_word[{lane, 3'b000} +: 8];
    sel_half  = rd_word[{lane[1], 4'b0000} +: 16];
    load_data = rd_word;
    case (size)
      SZ_BYTE: load_data = {{24{~uns & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_data = {{16{~uns & sel_half[15]}}, sel_half};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]     = new_data[7:0];
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
      default: merged = new_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_lsu.sv
// +----------------------------------------------------------------------+
// | dm_lsu   : core load/store initiator for word-organised data memory  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-9:0] BASE_HI = DM_BASE_HI
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_uns_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wd_i,
  output logic              lsu_stall_o,
  output logic              lsu_valid_o,
  output logic [31:0]       lsu_rd_o,
  output logic              lsu_err_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [31:0]       mem_wd_o,
  output logic              mem_we_o,
  input  logic [31:0]       mem_rd_i
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wbuf_q;
  logic              access_err;
  logic              accept;
  logic              we_dec;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  dm_lsu_lane u_lane (
    .rd_word   (mem_rd_i),
    .lane      (lsu_addr_i[1:0]),
    .size      (lsu_size_i),
    .uns       (lsu_uns_i),
    .old_word  (mem_rd_i),
    .new_data  (lsu_wd_i),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    access_err = (lsu_addr_i[ADDR_W-1:8] != BASE_HI)
              || (lsu_size_i == 2'b11)
              || ((lsu_size_i == SZ_HALF) && lsu_addr_i[0])
              || ((lsu_size_i == SZ_WORD) && (lsu_addr_i[1:0] != 2'b00));
    accept     = (state == IDLE) && lsu_req_i;
  end

  always_comb begin
    state_nxt   = state;
    lsu_stall_o = 1'b0;
    we_dec      = 1'b0;
    mem_a_o     = {lsu_addr_i[ADDR_W-1:2], 2'b00};
    mem_wd_o    = lsu_wd_i;
    case (state)
      IDLE: begin
        if (lsu_req_i) begin
          lsu_stall_o = 1'b1;
          if (access_err || !lsu_we_i) begin
            state_nxt = RESP;
          end else if (lsu_size_i == SZ_WORD) begin
            we_dec    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        lsu_stall_o = 1'b1;
        mem_a_o     = addr_q;
        mem_wd_o    = wbuf_q;
        we_dec      = 1'b1;
        state_nxt   = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Gated by reset so a store whose accept edge meets reset assertion never lands.
    mem_we_o = we_dec & rst_n_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      lsu_rd_o    <= 32'h0;
      lsu_valid_o <= 1'b0;
      lsu_err_o   <= 1'b0;
      addr_q      <= '0;
      wbuf_q      <= 32'h0;
    end else begin
      state       <= state_nxt;
      lsu_valid_o <= (state_nxt == RESP);
      lsu_err_o   <= accept && access_err;
      if (accept && !access_err && !lsu_we_i) begin
        lsu_rd_o <= load_data;
      end
      if (accept && !access_err && lsu_we_i && (lsu_size_i != SZ_WORD)) begin
        addr_q <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
        wbuf_q <= merged;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_lsu.sv
// +----------------------------------------------------------------------+
// | tb_dm_lsu : scoreboard bench for dm_lsu with a behavioural memory    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dm_lsu;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        stall;
  logic        valid;
  logic [31:0] rd;
  logic        err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [64];
  int          we_cnt = 0;
  logic [31:0] last_wd = 32'h0;
  logic [31:0] last_a = 32'h0;

  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] exp_rd;
  int          checks;
  int          failures;
  logic [31:0] obs_rd;
  logic        obs_err;
  int          obs_lat;
  int          obs_stall;

  dm_lsu #(.ADDR_W(32), .BASE_HI(24'h710000)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .lsu_req_i   (req),
    .lsu_we_i    (we),
    .lsu_size_i  (size),
    .lsu_uns_i   (uns),
    .lsu_addr_i  (addr),
    .lsu_wd_i    (wd),
    .lsu_stall_o (stall),
    .lsu_valid_o (valid),
    .lsu_rd_o    (rd),
    .lsu_err_o   (err),
    .mem_a_o     (mem_a),
    .mem_wd_o    (mem_wd),
    .mem_we_o    (mem_we),
    .mem_rd_i    (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_rd = (mem_a[31:8] == 24'h710000) ? mem[mem_a[7:2]] : 32'h0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      last_wd <= mem_wd;
      last_a  <= mem_a;
      if (mem_a[31:8] == 24'h710000) mem[mem_a[7:2]] <= mem_wd;
    end
  end

  // Drives one request (called just after a rising edge) and waits for completion.
  task automatic issue(input logic i_we, input logic [1:0] i_sz, input logic i_uns,
                       input logic [31:0] i_a, input logic [31:0] i_wd, input bit hold);
    bit got;
    got = 0;
    req = 1'b1; we = i_we; size = i_sz; uns = i_uns; addr = i_a; wd = i_wd;
    obs_lat = 0; obs_stall = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      obs_lat++;
      if (stall) obs_stall++;
      if (valid) begin
        got = 1; obs_rd = rd; obs_err = err;
        if (!hold) req = 1'b0;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL timeout addr=%h: no lsu_valid_o within 8 cycles", i_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; wd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd); end
    checks++; if (valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_valid_err got=%b%b exp=00", valid, err); end
    checks++; if (stall !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_stall_we got=%b%b exp=00", stall, mem_we); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_rd = 32'h0;
  endtask

  task automatic test_word();
    sbq.push_back('{1'b0, exp_rd});
    issue(1'b1, 2'b10, 1'b0, 32'h71000004, 32'h11223344, 0);
    e = sbq.pop_front();
    checks++; if (obs_err !== e.err || obs_rd !== e.rd) begin failures++; $display("FAIL word_store got=%b/%h exp=%b/%h", obs_err, obs_rd, e.err, e.rd); end
    checks++; if (obs_lat !== 2 || obs_stall !== 1) begin failures++; $display("FAIL word_store_timing got lat=%0d stall=%0d exp 2/1", obs_lat, obs_stall); end
    exp_rd = 32'h11223344;
    sbq.push_back('{1'b0, exp_rd});
    issue(1'b0, 2'b10, 1'b0, 32'h71000004, 32'h0, 0);
    e = sbq.pop_front();
    checks++; if (obs_err !== e.err || obs_rd !== e.rd) begin failures++; $display("FAIL word_load got=%b/%h exp=%b/%h", obs_err, obs_rd, e.err, e.rd); end
    checks++; if (obs_lat !== 2 || obs_stall !== 1) begin failures++; $display("FAIL word_load_timing got lat=%0d stall=%0d exp 2/1", obs_lat, obs_stall); end
  endtask

  task automatic test_subword_store();
    sbq.push_back('{1'b0, exp_rd});
    issue(1'b1, 2'b00, 1'b0, 32'h71000005, 32'hFFFFFFAB, 0);
    e = sbq.pop_front();
    checks++; if (obs_err !== e.err || obs_rd !== e.rd) begin failures++; $display("FAIL byte_store got=%b/%h exp=%b/%h", obs_err, obs_rd, e.err, e.rd); end
    checks++; if (last_wd !== 32'h1122AB44 || last_a !== 32'h71000004) begin failures++; $display("FAIL byte_store_wdata got=%h@%h exp=1122ab44@71000004", last_wd, last_a); end
    checks++; if (obs_lat !== 3 || obs_stall !== 2) begin failures++; $display("FAIL byte_store_timing got lat=%0d stall=%0d exp 3/2", obs_lat, obs_stall); end
    exp_rd = 32'h1122AB44;
    sbq.push_back('{1'b0, exp_rd});
    issue(1'b0, 2'b10, 1'b0, 32'h71000004, 32'h0, 0);
    e = sbq.pop_front();
    checks++; if (obs_rd !== e.rd) begin failures++; $display("FAIL byte_store_readback got=%h exp=%h", obs_rd, e.rd); end
  endtask

  task automatic test_extend();
    logic [1:0]  t_sz  [3] = '{2'b00, 2'b00, 2'b01};
    logic        t_uns [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] t_a   [3] = '{32'h71000009, 32'h71000009, 32'h71000008};
    logic [31:0] t_exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000};
    sbq.push_back('{1'b0, exp_rd});
    issue(1'b1, 2'b10, 1'b0, 32'h71000008, 32'h00008000, 0);
    e = sbq.pop_front();
    checks++; if (obs_err !== e.err) begin failures++; $display("FAIL ext_setup got=%b exp=%b", obs_err, e.err); end
    for (int i = 0; i < 3; i++) sbq.push_back('{1'b0, t_exp[i]});
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, t_sz[i], t_uns[i], t_a[i], 32'h0, 0);
      e = sbq.pop_front();
      checks++; if (obs_err !== e.err || obs_rd !== e.rd) begin failures++; $display("FAIL extend_%0d got=%b/%h exp=%b/%h", i, obs_err, obs_rd, e.err, e.rd); end
    end
    exp_rd = 32'hFFFF8000;
  endtask

  task automatic test_errors();
    logic        t_we  [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  t_sz  [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] t_a   [3] = '{32'h71000003, 32'h72000000, 32'h71000000};
    int          w0;
    w0 = we_cnt;
    for (int i = 0; i < 3; i++) sbq.push_back('{1'b1, exp_rd});
    for (int i = 0; i < 3; i++) begin
      issue(t_we[i], t_sz[i], 1'b0, t_a[i], 32'h0000BEEF, 0);
      e = sbq.pop_front();
      checks++; if (obs_err !== e.err || obs_rd !== e.rd) begin failures++; $display("FAIL error_%0d got=%b/%h exp=%b/%h", i, obs_err, obs_rd, e.err, e.rd); end
    end
    checks++; if (we_cnt !== w0) begin failures++; $display("FAIL error_no_write got=%0d writes exp=0", we_cnt - w0); end
    #0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid_op();
    int w0;
    sbq.push_back('{1'b0, exp_rd});
    issue(1'b1, 2'b10, 1'b0, 32'h7100000C, 32'hCAFED00D, 0);
    e = sbq.pop_front();
    checks++; if (obs_err !== e.err) begin failures++; $display("FAIL rst_setup got=%b exp=%b", obs_err, e.err); end
    w0 = we_cnt;
    req = 1'b1; we = 1'b1; size = 2'b01; uns = 1'b0; addr = 32'h7100000E; wd = 32'h0000BEEF;
    @(negedge clk);
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_write_state got we=%b exp=1", mem_we); end
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0;
    #1;
    checks++; if (rd !== 32'h0 || valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_async_outputs got=%h/%b/%b exp=0/0/0", rd, valid, err); end
    checks++; if (mem_we !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_async_we got we=%b stall=%b exp=0/0", mem_we, stall); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (we_cnt !== w0) begin failures++; $display("FAIL rst_dropped_write got=%0d writes exp=0", we_cnt - w0); end
    // Word store whose accept edge sees reset asserted.
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h7100000C; wd = 32'h12345678;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (we_cnt !== w0) begin failures++; $display("FAIL rst_edge_store got=%0d writes exp=0", we_cnt - w0); end
    exp_rd = 32'hCAFED00D;
    sbq.push_back('{1'b0, exp_rd});
    issue(1'b0, 2'b10, 1'b0, 32'h7100000C, 32'h0, 0);
    e = sbq.pop_front();
    checks++; if (obs_err !== e.err || obs_rd !== e.rd) begin failures++; $display("FAIL rst_recover got=%b/%h exp=%b/%h", obs_err, obs_rd, e.err, e.rd); end
  endtask

  task automatic test_back_to_back();
    sbq.push_back('{1'b0, 32'h1122AB44});
    sbq.push_back('{1'b0, 32'h00008000});
    issue(1'b0, 2'b10, 1'b0, 32'h71000004, 32'h0, 1);
    e = sbq.pop_front();
    checks++; if (obs_rd !== e.rd || obs_lat !== 2) begin failures++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=2", obs_rd, obs_lat, e.rd); end
    issue(1'b0, 2'b10, 1'b1, 32'h71000008, 32'h0, 0);
    e = sbq.pop_front();
    checks++; if (obs_rd !== e.rd || obs_err !== e.err) begin failures++; $display("FAIL b2b_second got=%b/%h exp=%b/%h", obs_err, obs_rd, e.err, e.rd); end
    checks++; if (obs_lat !== 2 || obs_stall !== 1) begin failures++; $display("FAIL b2b_not_in_resp got lat=%0d stall=%0d exp 2/1", obs_lat, obs_stall); end
    exp_rd = 32'h00008000;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_word();
    test_subword_store();
    test_extend();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    checks++; if (sbq.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Load/store initiator between the CPU core and the word-organised data memory.
- Memory side: word address, write data, write enable, combinational read data. The memory writes on posedge. Reads outside the 0x710000xx window return 0.
- Accepts byte, halfword and word loads and stores from the core, with zero or sign extension on loads.
- Sub-word stores are done as read-modify-write; misaligned or out-of-window accesses are flagged as errors.

Parameters:
- BASE_HI, 24'h710000, required value of addr[31:8] for a valid access.
- ADDR_W, 32, core/memory address width.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- lsu_req_i  in  1  core request; held stable by core while lsu_stall_o=1.
- lsu_we_i  in  1  1=store, 0=load.
- lsu_size_i  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as error).
- lsu_uns_i  in  1  load zero-extend (1) / sign-extend (0).
- lsu_addr_i  in  32  byte address.
- lsu_wd_i  in  32  store data, LSB-aligned.
- lsu_stall_o  out  1  core must hold its request.
- lsu_valid_o  out  1  one-cycle completion pulse.
- lsu_rd_o  out  32  extended load data; held until next completion.
- lsu_err_o  out  1  valid with lsu_valid_o: misaligned/out-of-window/reserved size.
- mem_a_o  out  32  word address {addr[31:2],2'b00} with addr[31:8] kept.
- mem_wd_o  out  32  memory write data.
- mem_we_o  out  1  memory write enable.
- mem_rd_i  in  32  memory read data (combinational from mem_a_o).

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: state=IDLE, lsu_rd_o=0, lsu_valid_o=0, lsu_err_o=0, address/wbuf registers 0.
- Because mem_we_o and lsu_stall_o decode from state, mem_we_o=0 immediately on reset assertion.
- Byte lanes are little-endian: byte k = bits [8k+7:8k]. Lane = addr[1:0]; half lane = addr[1].
- Error condition: addr[31:8]!=BASE_HI, or size=11, or half with addr[0]=1, or word with addr[1:0]!=0.

States and transitions:
- IDLE with lsu_req_i=0: mem_we_o=0, stall=0. mem_a_o is driven from lsu_addr_i, since a combinational read is harmless.
- IDLE with lsu_req_i=1: stall=1; mem_a_o = word address of lsu_addr_i.
  - Error: no write; latch err=1; go RESP. lsu_rd_o is unchanged on error.
  - Load: extract and extend the selected lane from mem_rd_i; register it into lsu_rd_o at the edge; err=0; go RESP. Latency is 2 cycles (accept, RESP).
  - Word store: mem_wd_o=lsu_wd_i and mem_we_o=1 in this cycle; go RESP.
  - Byte/half store: wbuf <= mem_rd_i with the lane(s) replaced by lsu_wd_i[7:0] or [15:0]; latch the word address; go WRITE.
- WRITE: stall=1, mem_a_o=latched address, mem_wd_o=wbuf, mem_we_o=1; go RESP.
- RESP: lsu_valid_o=1 with lsu_err_o; stall=0; mem_we_o=0; go IDLE unconditionally.
  - A request present in RESP is not accepted; it is taken in the following IDLE cycle. Back-to-back throughput is therefore one access per 2 (load/word store) or 3 (sub-word store) cycles.
- lsu_valid_o and lsu_err_o are registered: asserted exactly one cycle, in RESP only.
- Any state, rst_n_i=0 mid-operation: the pending write is dropped and memory is unchanged. A word store whose accept edge coincides with reset assertion is not written.

Decomposition:
- Package dm_lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum IDLE/WRITE/RESP;
  - BASE_HI default.
- One combinational sub-module, dm_lsu_lane, does two jobs:
  - load extract/extend: (word, addr[1:0], size, uns) -> 32-bit value;
  - store merge: (old word, new data, addr[1:0], size) -> merged word.

Test Plan:
- Word store 0x11223344 @0x71000004, then word load @0x71000004 -> lsu_rd_o=0x11223344, err=0, valid one cycle after accept, stall high only in the accept cycle.
- Byte store 0xAB @0x71000005 over 0x11223344 -> WRITE state drives mem_wd_o=0x1122AB44; subsequent word load returns 0x1122AB44.
- Memory word 0x00008000 @0x71000008: byte load @0x71000009, signed -> 0xFFFFFF80; unsigned -> 0x00000080; half load @0x71000008, signed -> 0xFFFF8000.
- Half store @0x71000003 and word load @0x72000000 -> err=1 with valid, mem_we_o never asserted, lsu_rd_o unchanged.
- Half store 0xBEEF @0x7100000E, with rst_n_i pulled low during WRITE -> outputs zero immediately, mem_we_o=0, word unchanged; after release the next load works normally.
- Request held during RESP -> ignored; accepted in the next IDLE cycle with correct data.
